// File: rtl/data_deb_if.sv
// Bundle of the debouncer's data/control inputs and filtered outputs.
// The slave modport is the debouncer side, master is the driver/observer side.
interface data_deb_if #(
  parameter int EDGE_WIDTH = 16
);
  logic                  data_i;
  logic                  clr_i;
  logic                  data_o;
  logic                  rise_o;
  logic                  fall_o;
  logic [EDGE_WIDTH-1:0] edge_cnt_o;
  logic [EDGE_WIDTH-1:0] glitch_cnt_o;

  modport master (
    output data_i, clr_i,
    input  data_o, rise_o, fall_o, edge_cnt_o, glitch_cnt_o
  );

  modport slave (
    input  data_i, clr_i,
    output data_o, rise_o, fall_o, edge_cnt_o, glitch_cnt_o
  );
endinterface

// File: rtl/data_deb.sv
// Debouncer and edge detector for an already-synchronized level: accepts a new
// level after STABLE_CYCLES consistent samples, counts accepted edges and glitches.
module data_deb #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_WIDTH     = 8,
  parameter int EDGE_WIDTH    = 16
) (
  input logic       clk_i,
  input logic       rst_i,
  data_deb_if.slave bus
);

  typedef enum logic [1:0] {
    LO_STABLE,
    CHK_HI,
    HI_STABLE,
    CHK_LO
  } state_t;

  localparam logic [CNT_WIDTH-1:0]  LAST_CNT = CNT_WIDTH'(STABLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0]  ONE_CNT  = CNT_WIDTH'(1);
  localparam logic [EDGE_WIDTH-1:0] ONE_EDGE = EDGE_WIDTH'(1);

  state_t                state_reg, state_next;
  logic [CNT_WIDTH-1:0]  cnt_reg, cnt_next;
  logic                  level_reg, level_next;
  logic                  rise_reg, rise_next;
  logic                  fall_reg, fall_next;
  logic [EDGE_WIDTH-1:0] edge_reg, edge_next;
  logic [EDGE_WIDTH-1:0] glitch_reg, glitch_next;
  logic                  edge_inc;
  logic                  glitch_inc;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg  <= LO_STABLE;
      cnt_reg    <= '0;
      level_reg  <= 1'b0;
      rise_reg   <= 1'b0;
      fall_reg   <= 1'b0;
      edge_reg   <= '0;
      glitch_reg <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      level_reg  <= level_next;
      rise_reg   <= rise_next;
      fall_reg   <= fall_next;
      edge_reg   <= edge_next;
      glitch_reg <= glitch_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    level_next = level_reg;
    rise_next  = 1'b0;
    fall_next  = 1'b0;
    edge_inc   = 1'b0;
    glitch_inc = 1'b0;

    case (state_reg)
      LO_STABLE: begin
        if (bus.data_i) begin
          state_next = CHK_HI;
          cnt_next   = ONE_CNT;
        end else begin
          cnt_next   = '0;
        end
      end
      CHK_HI: begin
        if (!bus.data_i) begin
          state_next = LO_STABLE;
          cnt_next   = '0;
          glitch_inc = 1'b1;
        // >= keeps cnt bounded even if it were ever outside the legal range
        end else if (cnt_reg >= LAST_CNT) begin
          state_next = HI_STABLE;
          cnt_next   = '0;
          level_next = 1'b1;
          rise_next  = 1'b1;
          edge_inc   = 1'b1;
        end else begin
          cnt_next   = cnt_reg + ONE_CNT;
        end
      end
      HI_STABLE: begin
        if (!bus.data_i) begin
          state_next = CHK_LO;
          cnt_next   = ONE_CNT;
        end else begin
          cnt_next   = '0;
        end
      end
      CHK_LO: begin
        if (bus.data_i) begin
          state_next = HI_STABLE;
          cnt_next   = '0;
          glitch_inc = 1'b1;
        end else if (cnt_reg >= LAST_CNT) begin
          state_next = LO_STABLE;
          cnt_next   = '0;
          level_next = 1'b0;
          fall_next  = 1'b1;
          edge_inc   = 1'b1;
        end else begin
          cnt_next   = cnt_reg + ONE_CNT;
        end
      end
      default: begin
        state_next = LO_STABLE;
        cnt_next   = '0;
      end
    endcase
  end

  // A clear on the same cycle as an increment wins; counters wrap silently.
  always_comb begin
    edge_next   = edge_reg;
    glitch_next = glitch_reg;
    if (bus.clr_i) begin
      edge_next   = '0;
      glitch_next = '0;
    end else begin
      if (edge_inc) begin
        edge_next = edge_reg + ONE_EDGE;
      end
      if (glitch_inc) begin
        glitch_next = glitch_reg + ONE_EDGE;
      end
    end
  end

  assign bus.data_o       = level_reg;
  assign bus.rise_o       = rise_reg;
  assign bus.fall_o       = fall_reg;
  assign bus.edge_cnt_o   = edge_reg;
  assign bus.glitch_cnt_o = glitch_reg;

endmodule

// File: tb/tb_data_deb.sv
// Directed bench for data_deb: a run-length reference model pushes expected
// outputs per sampled cycle; a narrow-counter instance exercises wrap-around.
`timescale 1ns/100ps
module tb_data_deb;

  localparam int SC = 4;

  typedef struct {
    logic        d;
    logic        r;
    logic        f;
    logic [15:0] e;
    logic [15:0] g;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic data_drv;
  logic clr_drv;

  int checks = 0;
  int errors = 0;

  exp_t sb[$];

  logic        m_lvl;
  int          m_run;
  logic        m_rise, m_fall;
  logic [15:0] m_edge, m_glitch;

  always #2.5 clk = ~clk;

  data_deb_if #(.EDGE_WIDTH(16)) bus ();
  data_deb_if #(.EDGE_WIDTH(4))  wbus ();

  assign bus.data_i  = data_drv;
  assign bus.clr_i   = clr_drv;
  assign wbus.data_i = data_drv;
  assign wbus.clr_i  = clr_drv;

  data_deb #(.STABLE_CYCLES(SC), .CNT_WIDTH(8), .EDGE_WIDTH(16)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // Same stimulus, 4-bit counters: wraps after 16 events.
  data_deb #(.STABLE_CYCLES(SC), .CNT_WIDTH(8), .EDGE_WIDTH(4)) dut_wrap (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (wbus)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_lvl    = 1'b0;
    m_run    = 0;
    m_rise   = 1'b0;
    m_fall   = 1'b0;
    m_edge   = '0;
    m_glitch = '0;
    sb.delete();
  endtask

  // Counts how many consecutive samples disagree with the accepted level.
  task automatic model_step(input logic d, input logic clr);
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (d != m_lvl) begin
      m_run++;
      if (m_run == SC) begin
        m_lvl  = d;
        m_rise = d;
        m_fall = ~d;
        m_edge = m_edge + 16'd1;
        m_run  = 0;
      end
    end else begin
      if (m_run != 0) m_glitch = m_glitch + 16'd1;
      m_run = 0;
    end
    if (clr) begin
      m_edge   = '0;
      m_glitch = '0;
    end
  endtask

  task automatic cycle();
    exp_t x;
    @(posedge clk);
    model_step(data_drv, clr_drv);
    x.d = m_lvl; x.r = m_rise; x.f = m_fall; x.e = m_edge; x.g = m_glitch;
    sb.push_back(x);
    #1;
    x = sb.pop_front();
    chk("data_o", {15'd0, bus.data_o}, {15'd0, x.d});
    chk("rise_o", {15'd0, bus.rise_o}, {15'd0, x.r});
    chk("fall_o", {15'd0, bus.fall_o}, {15'd0, x.f});
    chk("edge_cnt", bus.edge_cnt_o, x.e);
    chk("glitch_cnt", bus.glitch_cnt_o, x.g);
    chk("rise_and_fall", {15'd0, bus.rise_o & bus.fall_o}, 16'd0);
    chk("wrap_edge_cnt", {12'd0, wbus.edge_cnt_o}, {12'd0, x.e[3:0]});
    chk("wrap_glitch_cnt", {12'd0, wbus.glitch_cnt_o}, {12'd0, x.g[3:0]});
  endtask

  // Called just after a sampled edge: reset asserts and releases between edges.
  task automatic async_reset(input string tag);
    #0.5 rst = 1'b1;
    #0.5;
    chk({tag, "_data_o"}, {15'd0, bus.data_o}, 16'd0);
    chk({tag, "_rise_o"}, {15'd0, bus.rise_o}, 16'd0);
    chk({tag, "_fall_o"}, {15'd0, bus.fall_o}, 16'd0);
    chk({tag, "_edge_cnt"}, bus.edge_cnt_o, 16'd0);
    chk({tag, "_glitch_cnt"}, bus.glitch_cnt_o, 16'd0);
    #1 rst = 1'b0;
    model_reset();
  endtask

  initial begin
    rst      = 1'b1;
    data_drv = 1'b0;
    clr_drv  = 1'b0;
    model_reset();

    // Reset state
    #3;
    chk("reset_data_o", {15'd0, bus.data_o}, 16'd0);
    chk("reset_edge_cnt", bus.edge_cnt_o, 16'd0);
    chk("reset_glitch_cnt", bus.glitch_cnt_o, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Quiet low input
    repeat (20) cycle();

    // Sustained high: rise on the 4th high sample
    data_drv = 1'b1;
    repeat (6) cycle();

    // Three-sample low glitch from HI_STABLE
    data_drv = 1'b0;
    repeat (3) cycle();
    data_drv = 1'b1;
    repeat (4) cycle();

    // Back to reset level, then toggle every 3 ns against the 5 ns clock
    async_reset("pre_toggle");
    #0.5;
    fork
      begin
        for (int i = 0; i < 41; i++) begin
          #3 data_drv = ~data_drv;
        end
      end
    join_none
    repeat (26) cycle();
    chk("toggle_data_o", {15'd0, bus.data_o}, 16'd0);
    data_drv = 1'b0;
    repeat (5) cycle();

    // Many accepted edges; wraps the narrow instance's counters
    for (int i = 0; i < 20; i++) begin
      data_drv = ~data_drv;
      repeat (SC + 1) cycle();
    end

    // Clear coinciding with an accepted edge
    data_drv = ~data_drv;
    repeat (SC - 1) cycle();
    clr_drv = 1'b1;
    cycle();
    clr_drv = 1'b0;
    repeat (2) cycle();

    // Clear coinciding with a glitch
    data_drv = ~data_drv;
    cycle();
    data_drv = ~data_drv;
    clr_drv  = 1'b1;
    cycle();
    clr_drv  = 1'b0;
    repeat (2) cycle();

    // Return low, then reset mid CHK_HI with two high samples counted
    data_drv = 1'b0;
    repeat (SC + 1) cycle();
    data_drv = 1'b1;
    repeat (2) cycle();
    async_reset("mid_check");
    repeat (SC + 2) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
